fb_scanout: RTL and testbench

//  Display-side consumer of the double-buffered frame buffer SRAM: generates raster timing, streams pixels from the

---
 rtl/fb_scanout_pkg.sv | 36 +++
 rtl/fb_scanout_timing.sv | 63 ++++++
 rtl/fb_scanout.sv | 136 +++++++++++++
 tb/tb_fb_scanout.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_scanout_pkg.sv
// fb_scanout_pkg: shared definitions for the frame-buffer scanout block.
//   - Default 640x480@60 raster timing constants (H_*_DEF / V_*_DEF).
//   - color_t / fb_addr_t pixel and frame-buffer address types.
//   - flip_state_t for the buffer-swap FSM, disp_ctl_t for the display control bundle.
//   - bar_color(): test-pattern colour from a 3-bit bar index.
package fb_scanout_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int ADDR_SIZE  = 19;
    localparam int COLOR_BITS = 8;

    typedef logic [COLOR_BITS-1:0] color_t;
    typedef logic [ADDR_SIZE-1:0]  fb_addr_t;

    typedef enum logic {
        FLIP_IDLE,
        FLIP_PENDING
    } flip_state_t;

    // Replicate the bar index across the pixel, LSB first, so every bar is a distinct grey/colour.
    function automatic color_t bar_color(input logic [2:0] bar);
        color_t c;
        for (int i = 0; i < COLOR_BITS; i++) c[i] = bar[i % 3];
        return c;
    endfunction

endpackage

// File: rtl/fb_scanout_timing.sv
// video_timing_gen: raster counters and stage0 decode for fb_scanout.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          run raster; low parks counters at (0,0)
//   h_cnt, v_cnt    current raster position (stage0)
//   active          position is inside the visible window
//   hsync_n/vsync_n active-low sync pulses (stage0, not yet pipeline-aligned)
//   frame_start     one-cycle pulse at (0,0) while running
module video_timing_gen
    import fb_scanout_pkg::*;
#(
    parameter  int H_ACTIVE = H_ACTIVE_DEF,
    parameter  int H_FP     = H_FP_DEF,
    parameter  int H_SYNC   = H_SYNC_DEF,
    parameter  int H_BP     = H_BP_DEF,
    parameter  int V_ACTIVE = V_ACTIVE_DEF,
    parameter  int V_FP     = V_FP_DEF,
    parameter  int V_SYNC   = V_SYNC_DEF,
    parameter  int V_BP     = V_BP_DEF,
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          frame_start
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Everything is gated with enable so a disabled raster looks like permanent blanking,
    // even in the single cycle before the counters are parked.
    always_comb begin
        active      = enable && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hsync_n     = !(enable && (int'(h_cnt) >= H_ACTIVE + H_FP)
                               && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC));
        vsync_n     = !(enable && (int'(v_cnt) >= V_ACTIVE + V_FP)
                               && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC));
        // Held low during reset so the pulse first appears on the (0,0) cycle after release.
        frame_start = enable && !rst && (h_cnt == '0) && (v_cnt == '0);
    end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: display-side consumer of the double-buffered frame buffer.
// Streams the front buffer through its single read port (read latency 1), drives
// hsync/vsync/de/rgb with all display outputs aligned two cycles after the raster
// counters, and turns a render_done pulse into one fb_flip at the next vblank start.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enable            run scanout; low holds raster at origin
//   render_done       back buffer complete (1-cycle pulse)
//   fb_read_addr      front-buffer read address; fb_data_out returns its pixel
//   fb_flip/flip_ack  1-cycle swap pulse; flip_pending while waiting for vblank
//   frame_start       raster at (0,0), stage0 timing
//   hsync, vsync, de, rgb  display outputs (syncs active low)
// Build option: FB_SCANOUT_TESTPATTERN_EN adds input test_mode selecting 8 colour bars.
module fb_scanout
    import fb_scanout_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     enable,
    input  logic     render_done,
`ifdef FB_SCANOUT_TESTPATTERN_EN
    input  logic     test_mode,
`endif
    output fb_addr_t fb_read_addr,
    input  color_t   fb_data_out,
    output logic     fb_flip,
    output logic     flip_pending,
    output logic     flip_ack,
    output logic     frame_start,
    output logic     hsync,
    output logic     vsync,
    output logic     de,
    output color_t   rgb
);

    localparam int HW     = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW     = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int STAGES = 2;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, hsync_n, vsync_n, vblank_start;

    // Stage1..STAGES copies of the stage0 control; index STAGES drives the pins.
    logic [STAGES:1] vld_pipe, hs_pipe, vs_pipe;
    color_t          pix_s1;
    flip_state_t     flip_state, flip_state_nxt;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .active      (active),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .frame_start (frame_start)
    );

    assign vblank_start = enable && !rst && (h_cnt == '0) && (int'(v_cnt) == V_ACTIVE);

    // Stage1 address: the first visible pixel of a frame is always frame_start, so
    // restarting there keeps the address in 0..H_ACTIVE*V_ACTIVE-1 without a bound check.
    always_ff @(posedge clk) begin
        if (rst || !enable)
            fb_read_addr <= '0;
        else if (active)
            fb_read_addr <= frame_start ? '0 : fb_read_addr + fb_addr_t'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            hs_pipe  <= '1;
            vs_pipe  <= '1;
            rgb      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], active};
            hs_pipe  <= {hs_pipe[STAGES-1:1], hsync_n};
            vs_pipe  <= {vs_pipe[STAGES-1:1], vsync_n};
            rgb      <= vld_pipe[1] ? pix_s1 : '0;
        end
    end

    assign de    = vld_pipe[STAGES];
    assign hsync = hs_pipe[STAGES];
    assign vsync = vs_pipe[STAGES];

`ifdef FB_SCANOUT_TESTPATTERN_EN
    // Bar index travels with the address so the pattern keeps the same latency as SRAM data.
    logic [2:0] bar_s1;
    always_ff @(posedge clk) begin
        if (rst) bar_s1 <= '0;
        else     bar_s1 <= 3'((int'(h_cnt) * 8) / H_ACTIVE);
    end
    assign pix_s1 = test_mode ? bar_color(bar_s1) : fb_data_out;
`else
    assign pix_s1 = fb_data_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) flip_state <= FLIP_IDLE;
        else     flip_state <= flip_state_nxt;
    end

    // A render_done seen while PENDING (or on the flip cycle itself) is absorbed.
    always_comb begin
        flip_state_nxt = flip_state;
        fb_flip        = 1'b0;
        case (flip_state)
            FLIP_IDLE:    if (render_done) flip_state_nxt = FLIP_PENDING;
            FLIP_PENDING: if (vblank_start) begin
                fb_flip        = 1'b1;
                flip_state_nxt = FLIP_IDLE;
            end
            default:      flip_state_nxt = FLIP_IDLE;
        endcase
    end

    assign flip_ack     = fb_flip;
    assign flip_pending = (flip_state == FLIP_PENDING);

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout on a reduced 8x4 raster
// (H 8/2/2/2, V 4/1/1/1 -> 14 cycles/line, 98 cycles/frame). The SRAM is modelled
// as data = addr[7:0], presented in the cycle the address is held, so pixel
// (h,v) appears on rgb two cycles after its raster position with value v*8+h.
module tb_fb_scanout;
    import fb_scanout_pkg::*;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 14
    localparam int FT = HT * (VA + VF + VS + VB); // 98

    logic     clk = 1'b0;
    logic     rst, enable, render_done;
    fb_addr_t fb_read_addr;
    color_t   fb_data_out, rgb;
    logic     fb_flip, flip_pending, flip_ack, frame_start, hsync, vsync, de;

    int checks = 0, failures = 0;
    int c = 0;            // cycles since raster restarted at (0,0)
    bit raster_on = 1'b0;
    int flips = 0, de_cnt = 0, hs_low = 0, cc = 0;

    always #5 clk = ~clk;

    assign fb_data_out = fb_read_addr[7:0];

    fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .render_done  (render_done),
`ifdef FB_SCANOUT_TESTPATTERN_EN
        .test_mode    (1'b0),
`endif
        .fb_read_addr (fb_read_addr),
        .fb_data_out  (fb_data_out),
        .fb_flip      (fb_flip),
        .flip_pending (flip_pending),
        .flip_ack     (flip_ack),
        .frame_start  (frame_start),
        .hsync        (hsync),
        .vsync        (vsync),
        .de           (de),
        .rgb          (rgb)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".addr"},   int'(fb_read_addr), 0);
        chk({tag, ".hsync"},  int'(hsync), 1);
        chk({tag, ".vsync"},  int'(vsync), 1);
        chk({tag, ".de"},     int'(de), 0);
        chk({tag, ".rgb"},    int'(rgb), 0);
        chk({tag, ".flip"},   int'(fb_flip), 0);
        chk({tag, ".ack"},    int'(flip_ack), 0);
        chk({tag, ".pend"},   int'(flip_pending), 0);
        chk({tag, ".fstart"}, int'(frame_start), 0);
    endtask

    // Expected raster outputs for cycle c, derived from frame position only.
    task automatic raster_check();
        int q, h, v, e_de, e_hs, e_vs, e_rgb, e_addr;
        h = (c % FT) % HT;
        v = (c % FT) / HT;
        chk($sformatf("fstart@%0d", c), int'(frame_start), int'(h == 0 && v == 0));
        if (c < 2) begin
            e_de = 0; e_hs = 1; e_vs = 1; e_rgb = 0;
        end else begin
            q = (c - 2) % FT;
            h = q % HT;
            v = q / HT;
            e_de  = int'(h < HA && v < VA);
            e_hs  = int'(!(h >= HA + HF && h < HA + HF + HS));
            e_vs  = int'(!(v >= VA + VF && v < VA + VF + VS));
            e_rgb = (e_de != 0) ? v * HA + h : 0;
        end
        if (c == 0) e_addr = 0;
        else begin
            q = (c - 1) % FT;
            h = q % HT;
            v = q / HT;
            if (v >= VA)     e_addr = HA * VA - 1;
            else if (h < HA) e_addr = v * HA + h;
            else             e_addr = v * HA + HA - 1;
        end
        chk($sformatf("de@%0d", c),    int'(de),    e_de);
        chk($sformatf("hsync@%0d", c), int'(hsync), e_hs);
        chk($sformatf("vsync@%0d", c), int'(vsync), e_vs);
        chk($sformatf("rgb@%0d", c),   int'(rgb),   e_rgb);
        chk($sformatf("addr@%0d", c),  int'(fb_read_addr), e_addr);
    endtask

    // One clock: inputs change just after the edge, outputs are sampled on the falling edge.
    task automatic step(input logic r, input logic en, input logic rd);
        @(posedge clk);
        #1;
        rst = r; enable = en; render_done = rd;
        @(negedge clk);
        if (raster_on) raster_check();
        if (fb_flip) flips++;
        c++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b1; render_done = 1'b0;
        repeat (3) step(1'b1, 1'b1, 1'b0);
        reset_check("por");

        // Run mid-frame, request a flip, then reset: the request must be lost.
        raster_on = 1'b1; c = 0;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'(i == 20));
        chk("pend_before_rst", int'(flip_pending), 1);
        raster_on = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        reset_check("rst_mid1");
        step(1'b1, 1'b1, 1'b0);
        reset_check("rst_mid3");

        // Two free-running frames.
        raster_on = 1'b1; c = 0; flips = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (de)     de_cnt++;
            if (!hsync) hs_low++;
        end
        chk("de_cycles", de_cnt, 64);
        chk("hsync_low_cycles", hs_low, 28);
        chk("lost_flip", flips, 0);

        // render_done on line 1 -> flip at (0,4) of the same frame.
        flips = 0;
        for (int i = 0; i < FT; i++) begin
            cc = c;
            step(1'b0, 1'b1, 1'(cc == 210));
            if (cc == 211) chk("pend_set", int'(flip_pending), 1);
            if (cc == 252) begin
                chk("flip_at_vblank", int'(fb_flip), 1);
                chk("ack_at_vblank", int'(flip_ack), 1);
                chk("pend_at_flip", int'(flip_pending), 1);
            end
            if (cc == 253) chk("pend_clr", int'(flip_pending), 0);
        end
        chk("flips_frame3", flips, 1);

        // render_done exactly at vblank start while idle -> flip one frame later.
        flips = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            cc = c;
            step(1'b0, 1'b1, 1'(cc == 350));
            if (cc == 350) chk("no_flip_same_cycle", int'(fb_flip), 0);
            if (cc == 351) chk("pend_late_rd", int'(flip_pending), 1);
            if (cc == 448) chk("flip_next_frame", int'(fb_flip), 1);
        end
        chk("flips_late_rd", flips, 1);

        // Two requests before vblank -> one flip.
        flips = 0;
        for (int i = 0; i < FT; i++) begin
            cc = c;
            step(1'b0, 1'b1, 1'(cc == 495 || cc == 500));
            if (cc == 501) chk("pend_double", int'(flip_pending), 1);
            if (cc == 546) chk("flip_double", int'(fb_flip), 1);
        end
        chk("flips_double", flips, 1);

        // Disabled for 20 cycles: blank outputs, request accepted but no flip.
        raster_on = 1'b0; flips = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'(i == 5));
            if (i >= 2) begin
                chk("dis.de", int'(de), 0);
                chk("dis.hsync", int'(hsync), 1);
                chk("dis.vsync", int'(vsync), 1);
                chk("dis.rgb", int'(rgb), 0);
            end
            if (i >= 1) chk("dis.addr", int'(fb_read_addr), 0);
            if (i == 10) chk("dis.fstart", int'(frame_start), 0);
            if (i == 6) chk("dis.pend", int'(flip_pending), 1);
        end
        chk("no_flip_disabled", flips, 0);

        // Re-enable: restart at (0,0) and the held request flips at the first vblank.
        raster_on = 1'b1; c = 0; flips = 0;
        for (int i = 0; i < FT; i++) begin
            cc = c;
            step(1'b0, 1'b1, 1'b0);
            if (cc == 56) chk("flip_after_enable", int'(fb_flip), 1);
        end
        chk("flips_after_enable", flips, 1);
        chk("pend_after_enable", int'(flip_pending), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
